// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: tap delay line, coefficient store and one MAC
// stepped over all taps for each accepted sample, with valid/ready on both sides.
module fir_mac_sequencer #(
    parameter int TAPS = 8,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int SW   = 3,
    parameter int AW   = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [AW-1:0] out_data,
    input  logic                 out_ready,
    input  logic                 coef_we,
    input  logic        [SW-1:0] coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 coef_err,
    output logic        [SW-1:0] tap_sel,
    output logic                 busy
);

    // state | meaning
    // IDLE  | waiting for a sample, coefficient writes allowed
    // RUN   | one MAC step per edge over tap_sel 0..TAPS-1
    // DONE  | result held on out_data until the consumer takes it
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic signed [DW-1:0]    taps [TAPS];
    logic signed [CW-1:0]    coef [TAPS];
    logic signed [AW-1:0]    acc;
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    acc_sum;
    logic                    accept;
    logic                    last_step;

    assign prod      = taps[tap_sel] * coef[tap_sel];
    assign acc_sum   = acc + {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
    assign last_step = (tap_sel == SW'(TAPS-1));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                taps[k] <= '0;
                coef[k] <= (k % 2 == 0) ? CW'(1) : CW'(0);
            end
            acc      <= '0;
            tap_sel  <= '0;
            out_data <= '0;
            coef_err <= 1'b0;
        end else begin
            coef_err <= 1'b0;
            // The MAC reads coef combinationally, so writes are refused while it runs.
            if (coef_we) begin
                if (state == RUN) coef_err <= 1'b1;
                else coef[coef_addr] <= coef_data;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        taps[0] <= in_data;
                        for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
                        acc     <= '0;
                        tap_sel <= '0;
                    end
                end
                RUN: begin
                    acc     <= acc_sum;
                    tap_sel <= tap_sel + SW'(1);
                    if (last_step) out_data <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a scoreboard fed by a behavioural FIR model.
module tb_fir_mac_sequencer;

    localparam int TAPS = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic signed [18:0] out_data;
    logic              out_ready = 1'b0;
    logic              coef_we = 1'b0;
    logic        [2:0] coef_addr = '0;
    logic signed [7:0] coef_data = '0;
    logic              coef_err;
    logic        [2:0] tap_sel;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;
    int m_taps [TAPS];
    int m_coef [TAPS];
    int q [$];

    fir_mac_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_err(coef_err), .tap_sel(tap_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting on DUT", tag);
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_taps[k] = 0;
            m_coef[k] = (k % 2 == 0) ? 1 : 0;
        end
        q.delete();
    endtask

    task automatic model_push(input int d);
        int sum;
        for (int k = TAPS-1; k > 0; k--) m_taps[k] = m_taps[k-1];
        m_taps[0] = d;
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += m_taps[k] * m_coef[k];
        q.push_back(sum);
    endtask

    // Offer a sample (optionally with a same-edge coefficient write); returns at the negedge after acceptance.
    task automatic offer(input int d, input bit we = 1'b0, input int a = 0, input int c = 0);
        int cnt;
        cnt = 0;
        in_valid  = 1'b1;
        in_data   = d[7:0];
        coef_we   = we;
        coef_addr = a[2:0];
        coef_data = c[7:0];
        while (!in_ready && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            timeout("accept");
            in_valid = 1'b0;
            coef_we  = 1'b0;
            return;
        end
        if (we) m_coef[a] = c;
        model_push(d);
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        check("busy_in_run", int'(busy), 1);
        check("in_ready_in_run", int'(in_ready), 0);
    endtask

    task automatic wait_result(input int exp_lat);
        int cnt;
        int exp_v;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (!out_valid) begin
            timeout("out_valid");
            return;
        end
        if (exp_lat >= 0) check("latency", cnt, exp_lat);
        if (q.size() == 0) begin
            timeout("scoreboard_empty");
        end else begin
            exp_v = q.pop_front();
            check("out_data", int'(out_data), exp_v);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", int'(out_valid), 0);
    endtask

    task automatic write_coef(input int a, input int c);
        coef_we   = 1'b1;
        coef_addr = a[2:0];
        coef_data = c[7:0];
        @(negedge clk);
        coef_we = 1'b0;
        m_coef[a] = c;
        check("coef_err_idle_write", int'(coef_err), 0);
    endtask

    task automatic poll_tap_sel(input int target);
        int cnt;
        cnt = 0;
        while (int'(tap_sel) != target && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (int'(tap_sel) != target) timeout("tap_sel_poll");
    endtask

    initial begin
        int hold_v;
        model_reset();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tap_sel", int'(tap_sel), 0);
        check("rst_out_data", int'(out_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_coef_err", int'(coef_err), 0);

        // Impulse through the reset coefficient pattern
        offer(1); wait_result(TAPS);
        for (int i = 0; i < TAPS; i++) begin
            offer(0); wait_result(TAPS);
        end

        // Ramp coefficients
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        offer(1); wait_result(TAPS);
        for (int i = 0; i < TAPS-1; i++) begin
            offer(0); wait_result(TAPS);
        end

        // All -1 coefficients, constant 127
        for (int k = 0; k < TAPS; k++) write_coef(k, -1);
        for (int i = 0; i < TAPS; i++) begin
            offer(127); wait_result(TAPS);
        end

        // Extremes: -128 * -128 across every tap
        for (int k = 0; k < TAPS; k++) write_coef(k, -128);
        for (int i = 0; i < TAPS; i++) begin
            offer(-128); wait_result(-1);
        end
        check("extreme_steady_expected", m_taps[TAPS-1] * m_coef[TAPS-1] * TAPS, 131072);

        // Write landing on the same IDLE edge as an acceptance
        offer(3, 1'b1, 0, 5); wait_result(TAPS);

        // Backpressure in DONE with a new sample already offered
        offer(5);
        begin
            int cnt;
            cnt = 0;
            while (!out_valid && cnt < 40) begin
                @(negedge clk);
                cnt++;
            end
            if (!out_valid) timeout("bp_out_valid");
        end
        hold_v = (q.size() > 0) ? q.pop_front() : 0;
        in_valid = 1'b1;
        in_data  = 8'sd7;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'(out_data), hold_v);
            check("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_in_ready_after_release", int'(in_ready), 1);
        offer(7); wait_result(TAPS);

        // Coefficient write attempted mid-MAC is dropped
        offer(-9);
        poll_tap_sel(3);
        coef_we   = 1'b1;
        coef_addr = 3'd2;
        coef_data = 8'sd99;
        @(negedge clk);
        coef_we = 1'b0;
        check("coef_err_pulse", int'(coef_err), 1);
        @(negedge clk);
        check("coef_err_clear", int'(coef_err), 0);
        wait_result(-1);
        offer(11); wait_result(TAPS);

        // Asynchronous reset in the middle of a MAC
        offer(1);
        poll_tap_sel(5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_tap_sel", int'(tap_sel), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (TAPS + 2) begin
            @(negedge clk);
            check("arst_no_stale_valid", int'(out_valid), 0);
        end
        offer(1); wait_result(TAPS);
        for (int i = 0; i < 3; i++) begin
            offer(0); wait_result(TAPS);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
